lampfpu_sqrt_arb: RTL

Round-robin arbiter and sequencer that shares one multi-cycle lampFPU_sqrt unit among N_REQ requesters. It accepts packed bfloat16-format operands (1/8/7 sign/exponent/fraction) and unpacks and classifies each one into the extended operand fields the sqrt unit takes. It drives doSqrt until the unit reports valid, then holds the result on a single tagged response channel with backpressure. An optional watchdog aborts a hung operation.

---
 rtl/lampfpu_sqrt_arb.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/lampfpu_sqrt_arb.sv
// Round-robin front end that shares one multi-cycle lampFPU sqrt unit among N_REQ requesters.
// Operands are unpacked/classified at grant; an optional watchdog forces a qNaN response.
module lampfpu_sqrt_arb #(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 64,
   parameter int ID_W    = $clog2(N_REQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_REQ-1:0]      req_i,
   input  logic [N_REQ-1:0]      invSqrt_req_i,
   input  logic [16*N_REQ-1:0]   op_req_i,
   output logic [N_REQ-1:0]      gnt_o,
   output logic                  busy_o,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [ID_W-1:0]       rsp_id_o,
   output logic [15:0]           rsp_res_o,
   output logic                  rsp_timeout_o,
   output logic                  doSqrt_o,
   output logic                  invSqrt_o,
   output logic                  signum_op_o,
   output logic [7:0]            extExp_op_o,
   output logic [7:0]            extMant_op_o,
   output logic                  isZero_op_o,
   output logic                  isInf_op_o,
   output logic                  isSNAN_op_o,
   output logic                  isQNAN_op_o,
   input  logic                  valid_i,
   input  logic                  s_res_i,
   input  logic [7:0]            e_res_i,
   input  logic [6:0]            f_res_i
);

   // state  | meaning
   // S_IDLE | waiting for a request, grant is combinational
   // S_BUSY | doSqrt held high, waiting for valid_i or watchdog
   // S_RESP | result presented until rsp_ready_i
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_RESP = 2'd2} state_t;

   localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

   state_t            r_state, w_state_nxt;
   logic [ID_W-1:0]   r_ptr, r_id;
   logic [CNT_W-1:0]  r_wd_cnt;
   logic [15:0]       r_res;
   logic              r_to, r_inv, r_sign, r_zero, r_inf, r_snan, r_qnan;
   logic [7:0]        r_exp, r_mant;

   logic [N_REQ-1:0]  w_rot, w_gnt;
   logic [ID_W-1:0]   w_off, w_gnt_id;
   logic [ID_W:0]     w_sum;
   logic              w_any, w_wd_hit;
   logic [15:0]       w_op;
   logic [7:0]        w_e;
   logic [6:0]        w_f;

   // Rotate so bit 0 is the requester at the pointer; lowest set bit wins.
   assign w_rot = N_REQ'({req_i, req_i} >> r_ptr);

   always_comb begin
      w_any = 1'b0;
      w_off = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            w_any = 1'b1;
            w_off = ID_W'(k);
         end
      end
   end

   assign w_sum    = {1'b0, r_ptr} + {1'b0, w_off};
   assign w_gnt_id = (w_sum >= (ID_W+1)'(N_REQ)) ? ID_W'(w_sum - (ID_W+1)'(N_REQ)) : ID_W'(w_sum);
   assign w_gnt    = w_any ? (N_REQ'(1) << w_gnt_id) : '0;
   assign w_op     = op_req_i[w_gnt_id*16 +: 16];
   assign w_e      = w_op[14:7];
   assign w_f      = w_op[6:0];
   assign w_wd_hit = (TIMEOUT != 0) && (r_wd_cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      gnt_o       = '0;
      doSqrt_o    = 1'b0;
      rsp_valid_o = 1'b0;
      busy_o      = 1'b1;
      case (r_state)
         S_IDLE: begin
            busy_o = 1'b0;
            if (!rst) gnt_o = w_gnt;
            if (w_any) w_state_nxt = S_BUSY;
         end
         S_BUSY: begin
            doSqrt_o = 1'b1;
            if (valid_i || w_wd_hit) w_state_nxt = S_RESP;
         end
         S_RESP: begin
            rsp_valid_o = 1'b1;
            if (rsp_ready_i) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= '0;  r_id <= '0;  r_wd_cnt <= '0;  r_res <= '0;  r_to <= 1'b0;
         r_inv <= 1'b0; r_sign <= 1'b0; r_exp <= '0; r_mant <= '0;
         r_zero <= 1'b0; r_inf <= 1'b0; r_snan <= 1'b0; r_qnan <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (w_any) begin
               r_ptr  <= (w_gnt_id == ID_W'(N_REQ - 1)) ? '0 : w_gnt_id + 1'b1;
               r_id   <= w_gnt_id;
               r_inv  <= invSqrt_req_i[w_gnt_id];
               r_sign <= w_op[15];
               r_exp  <= (w_e == 8'h00) ? 8'h01 : w_e;
               r_mant <= {w_e != 8'h00, w_f};
               r_zero <= (w_e == 8'h00) && (w_f == 7'h00);
               r_inf  <= (w_e == 8'hFF) && (w_f == 7'h00);
               r_qnan <= (w_e == 8'hFF) && w_f[6];
               r_snan <= (w_e == 8'hFF) && (w_f != 7'h00) && !w_f[6];
            end
            S_BUSY: begin
               r_wd_cnt <= r_wd_cnt + 1'b1;
               if (valid_i) begin
                  r_res <= {s_res_i, e_res_i, f_res_i};
                  r_to  <= 1'b0;
               end else if (w_wd_hit) begin
                  r_res <= 16'h7FC0;
                  r_to  <= 1'b1;
               end
            end
            S_RESP: if (rsp_ready_i) r_wd_cnt <= '0;
            default: ;
         endcase
      end
   end

   assign rsp_id_o      = r_id;
   assign rsp_res_o     = r_res;
   assign rsp_timeout_o = r_to;
   assign invSqrt_o     = r_inv;
   assign signum_op_o   = r_sign;
   assign extExp_op_o   = r_exp;
   assign extMant_op_o  = r_mant;
   assign isZero_op_o   = r_zero;
   assign isInf_op_o    = r_inf;
   assign isSNAN_op_o   = r_snan;
   assign isQNAN_op_o   = r_qnan;

endmodule
